// File: rtl/fetch_unit.sv
// Instruction fetch: issues PCs to memory port A, queues the instr/pc pairs it returns, hands them to decode.
// Issue-to-ifValid is 2 cycles; credit-limited issue stops when queue+inflight would exceed QDEPTH.

module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wrVld,
    input  logic [WIDTH-1:0]         wrDat,
    input  logic                     rdRdy,
    output logic                     rdVld,
    output logic [WIDTH-1:0]         rdDat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPop;

    assign rdVld = (count != '0);
    assign rdDat = store[rdPtr];
    assign doPop = rdVld & rdRdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrVld) begin
                store[wrPtr] <= wrDat;
                wrPtr        <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            count <= count + (PW+1)'(wrVld) - (PW+1)'(doPop);
        end
    end
endmodule

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic [31:0] memPcOut,
    output logic        memEn,
    input  logic [31:0] memInstr,
    input  logic [31:0] memPc,
    input  logic        memNotReady,
    output logic        ifValid,
    output logic [31:0] ifInstr,
    output logic [31:0] ifPc,
    input  logic        idReady
);
    localparam int CW = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetchEnt_t;

    logic [31:0]   fetchPc;
    logic          inflight;
    logic [31:0]   inflightPc;
    logic [CW-1:0] qCount;
    logic [CW:0]   credit;
    logic          pop;
    logic          push;
    logic          replay;
    fetchEnt_t     pushEnt;
    fetchEnt_t     headEnt;

    assign memPcOut = fetchPc;
    assign pop      = ifValid & idReady;
    assign replay   = inflight & memNotReady;
    assign push     = inflight & ~memNotReady & ~redirect;
    assign pushEnt  = '{instr: memInstr, pc: inflightPc};

    // Occupancy after this cycle's pop, counting the response still on its way back.
    assign credit = {1'b0, qCount} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign memEn  = reset & ~redirect & ~replay & (credit < (CW+1)'(QDEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPc    <= RESET_PC;
            inflight   <= 1'b0;
            inflightPc <= '0;
        end else if (redirect) begin
            fetchPc  <= redirectPc & ~32'd3;
            inflight <= 1'b0;
        end else begin
            inflight <= memEn;
            if (memEn) begin
                inflightPc <= fetchPc;
            end
            // A rejected response rewinds to its own PC; any same-cycle issue was already suppressed.
            if (replay) begin
                fetchPc <= inflightPc;
            end else if (memEn) begin
                fetchPc <= fetchPc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetchEnt_t)),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .wrVld (push),
        .wrDat (pushEnt),
        .rdRdy (idReady),
        .rdVld (ifValid),
        .rdDat (headEnt),
        .count (qCount)
    );

    assign ifInstr = headEnt.instr;
    assign ifPc    = headEnt.pc;

    memPcEcho: assert property (@(posedge clk) disable iff (!reset)
        (inflight && !memNotReady) |-> (memPc == inflightPc));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-level reference model checked every cycle, plus literal
// expectations on the delivered PC stream for each scenario.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = '0;
    logic [31:0] memPcOut;
    logic        memEn;
    logic [31:0] memInstr = '0;
    logic [31:0] memPc = '0;
    logic        memNotReady = 1'b0;
    logic        ifValid;
    logic [31:0] ifInstr;
    logic [31:0] ifPc;
    logic        idReady = 1'b0;

    int vecs = 0;
    int errs = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    // Reference model state
    logic [31:0] mPc;
    bit          mInfl;
    logic [31:0] mInflPc;
    ent_t        mq[$];
    logic [31:0] dutLog[$];
    logic [31:0] expLog[$];

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirectPc  (redirectPc),
        .memPcOut    (memPcOut),
        .memEn       (memEn),
        .memInstr    (memInstr),
        .memPc       (memPc),
        .memNotReady (memNotReady),
        .ifValid     (ifValid),
        .ifInstr     (ifInstr),
        .ifPc        (ifPc),
        .idReady     (idReady)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instrAt(input logic [31:0] pc);
        return 32'h9300_1000 + (pc << 10);
    endfunction

    // Registered memory: response and pc echo appear the cycle after a request.
    always @(posedge clk) begin
        if (memEn) begin
            memPc    <= memPcOut;
            memInstr <= instrAt(memPcOut);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc     = RESET_PC;
        mInfl   = 1'b0;
        mInflPc = '0;
        mq.delete();
    endtask

    // Compare at negedge against the model, then advance the model by one clock.
    task automatic cycle();
        bit   pop;
        bit   issue;
        int   occ;
        ent_t head;
        @(negedge clk);
        pop   = (mq.size() != 0) && idReady;
        occ   = mq.size() + (mInfl ? 1 : 0) - (pop ? 1 : 0);
        issue = reset && !redirect && !(mInfl && memNotReady) && (occ < QDEPTH);
        check("memEn", {31'b0, memEn}, {31'b0, issue});
        check("memPcOut", memPcOut, mPc);
        check("ifValid", {31'b0, ifValid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            head = mq[0];
            check("ifPc", ifPc, head.pc);
            check("ifInstr", ifInstr, head.instr);
        end
        if (ifValid && idReady) dutLog.push_back(ifPc);
        if (!reset) begin
            modelReset();
        end else begin
            if (pop) void'(mq.pop_front());
            if (redirect) begin
                mq.delete();
                mInfl = 1'b0;
                mPc   = redirectPc & ~32'd3;
            end else begin
                if (mInfl && !memNotReady) mq.push_back('{instr: instrAt(mInflPc), pc: mInflPc});
                if (mInfl && memNotReady) begin
                    mPc = mInflPc;
                end else if (issue) begin
                    mInflPc = mPc;
                    mPc     = mPc + 32'd4;
                end
                mInfl = issue;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkLog(input string name);
        check({name, "_len"}, dutLog.size(), expLog.size());
        for (int i = 0; i < expLog.size() && i < dutLog.size(); i++) begin
            check(name, dutLog[i], expLog[i]);
        end
    endtask

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ifValid", {31'b0, ifValid}, 32'd0);
        check("rst_memEn", {31'b0, memEn}, 32'd0);
        check("rst_memPcOut", memPcOut, 32'h0000_0000);
        check("rst_ifPc", ifPc, 32'h0000_0000);
        check("rst_ifInstr", ifInstr, 32'h0000_0000);
        cycle();

        // Streaming from RESET_PC with decode always ready
        reset   = 1'b1;
        idReady = 1'b1;
        cycle();
        check("lat_ifValid_n1", {31'b0, ifValid}, 32'd0);
        cycle();
        check("lat_ifValid_n2", {31'b0, ifValid}, 32'd1);
        check("first_ifPc", ifPc, 32'h0000_0000);
        check("first_ifInstr", ifInstr, 32'h9300_1000);
        repeat (4) cycle();

        // Decode stalls for 5 cycles, then drains
        idReady = 1'b0;
        repeat (5) cycle();
        check("stall_memEn", {31'b0, memEn}, 32'd0);
        check("stall_ifPc", ifPc, 32'h0000_0010);
        idReady = 1'b1;
        repeat (4) cycle();
        expLog = {32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C};
        checkLog("stream");

        // Redirect to an unaligned target while work is queued and in flight
        dutLog.delete();
        idReady    = 1'b0;
        redirect   = 1'b1;
        redirectPc = 32'h0000_0043;
        cycle();
        redirect = 1'b0;
        idReady  = 1'b1;
        check("redir_ifValid", {31'b0, ifValid}, 32'd0);
        check("redir_memPcOut", memPcOut, 32'h0000_0040);
        repeat (5) cycle();
        expLog = {32'h40, 32'h44, 32'h48};
        checkLog("redirect");

        // Memory not ready on the response for PC 8
        dutLog.delete();
        idReady    = 1'b0;
        redirect   = 1'b1;
        redirectPc = 32'h0000_0000;
        cycle();
        redirect = 1'b0;
        idReady  = 1'b1;
        repeat (3) cycle();
        memNotReady = 1'b1;
        cycle();
        memNotReady = 1'b0;
        check("replay_memPcOut", memPcOut, 32'h0000_0008);
        repeat (5) cycle();
        expLog = {32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        checkLog("replay");

        // Address wrap at the top of the space
        dutLog.delete();
        idReady    = 1'b0;
        redirect   = 1'b1;
        redirectPc = 32'hFFFF_FFF8;
        cycle();
        redirect = 1'b0;
        idReady  = 1'b1;
        repeat (6) cycle();
        expLog = {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        checkLog("wrap");

        // Asynchronous reset between edges while a valid instruction is presented
        check("pre_rst_ifValid", {31'b0, ifValid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_ifValid", {31'b0, ifValid}, 32'd0);
        check("arst_memEn", {31'b0, memEn}, 32'd0);
        check("arst_memPcOut", memPcOut, RESET_PC);
        check("arst_ifPc", ifPc, 32'h0000_0000);
        modelReset();
        repeat (2) cycle();
        dutLog.delete();
        reset = 1'b1;
        repeat (5) cycle();
        expLog = {32'h0, 32'h4, 32'h8};
        checkLog("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
